inst_generator: RTL and testbench

//  Sequential stimulus source producing a stream of RV32IM-subset instructions that always satisfy
//  the QED instruction constraints: R/I/LW/SW/NOP only, all register fields < 16, LW/SW base x0,
//  LW/SW imm[11:10]=00, NOP opcode 7'h7F. It drives the core fetch port in simulation and emulation

---
 rtl/inst_generator.sv | 217 +++++++++++++++++++++
 tb/tb_inst_generator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_generator.sv
// inst_generator: seeded LFSR-driven source of constrained RV32IM-subset
// instructions (R / I / LW / SW / NOP) with a valid/ready handshake and a
// bounded-length run controller.
module inst_generator #(
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int unsigned NUM_INSTS = 16,
  parameter int unsigned CNT_W     = 16,
  parameter logic [4:0]  CLASS_EN  = 5'b11111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      instruction,
  output logic [2:0]       inst_class,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY     = 32'h8020_0003;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_NOP = 7'b1111111;

  localparam logic [2:0] CLS_R   = 3'd0;
  localparam logic [2:0] CLS_I   = 3'd1;
  localparam logic [2:0] CLS_LW  = 3'd2;
  localparam logic [2:0] CLS_SW  = 3'd3;
  localparam logic [2:0] CLS_NOP = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_lfsr;
  logic [31:0]      w_lfsr_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_hs;
  logic             w_last;

  logic [3:0]       w_idx_r;
  logic [3:0]       w_idx_i;
  logic [9:0]       w_rfunct;
  logic [2:0]       w_ifunct3;
  logic [11:0]      w_itop;
  logic [4:0]       w_rd;
  logic [4:0]       w_rs1;
  logic [4:0]       w_rs2;
  logic [31:0]      w_inst;
  logic [2:0]       w_cls;

  // Galois right-shift step; the taps keep a nonzero state nonzero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? POLY : 32'h0);
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // {funct7, funct3} for R-type index 0..13 (ADD .. MULHU).
  function automatic logic [9:0] r_funct(input logic [3:0] idx);
    case (idx)
      4'd0:    return {7'b0000000, 3'b000}; // ADD
      4'd1:    return {7'b0100000, 3'b000}; // SUB
      4'd2:    return {7'b0000000, 3'b001}; // SLL
      4'd3:    return {7'b0000000, 3'b010}; // SLT
      4'd4:    return {7'b0000000, 3'b011}; // SLTU
      4'd5:    return {7'b0000000, 3'b100}; // XOR
      4'd6:    return {7'b0000000, 3'b101}; // SRL
      4'd7:    return {7'b0100000, 3'b101}; // SRA
      4'd8:    return {7'b0000000, 3'b110}; // OR
      4'd9:    return {7'b0000000, 3'b111}; // AND
      4'd10:   return {7'b0000001, 3'b000}; // MUL
      4'd11:   return {7'b0000001, 3'b001}; // MULH
      4'd12:   return {7'b0000001, 3'b010}; // MULHSU
      4'd13:   return {7'b0000001, 3'b011}; // MULHU
      default: return {7'b0000000, 3'b000};
    endcase
  endfunction

  // funct3 for I-type index 0..8 (ADDI .. SRAI).
  function automatic logic [2:0] i_funct3(input logic [3:0] idx);
    case (idx)
      4'd0:    return 3'b000; // ADDI
      4'd1:    return 3'b010; // SLTI
      4'd2:    return 3'b011; // SLTIU
      4'd3:    return 3'b100; // XORI
      4'd4:    return 3'b110; // ORI
      4'd5:    return 3'b111; // ANDI
      4'd6:    return 3'b001; // SLLI
      4'd7:    return 3'b101; // SRLI
      4'd8:    return 3'b101; // SRAI
      default: return 3'b000;
    endcase
  endfunction

  assign w_hs   = (r_state == S_RUN) && out_ready;
  assign w_last = (NUM_INSTS != 0) &&
                  (({1'b0, r_count} + (CNT_W + 1)'(1)) == (CNT_W + 1)'(NUM_INSTS));

  // Run controller: next state, LFSR and transfer count.
  always_comb begin
    w_state_nxt = r_state;
    w_lfsr_nxt  = r_lfsr;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_lfsr_nxt  = SEED_EFF;
          w_count_nxt = '0;
        end
      end
      S_RUN: begin
        if (w_hs) begin
          w_lfsr_nxt  = lfsr_step(r_lfsr);
          w_count_nxt = sat_inc(r_count);
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, LFSR and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED_EFF;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Field extraction; register numbers are 4 bits zero-extended so they stay below 16.
  assign w_idx_r   = (r_lfsr[7:4] >= 4'd14) ? (r_lfsr[7:4] - 4'd14) : r_lfsr[7:4];
  assign w_idx_i   = (r_lfsr[7:4] >= 4'd9)  ? (r_lfsr[7:4] - 4'd9)  : r_lfsr[7:4];
  assign w_rd      = {1'b0, r_lfsr[11:8]};
  assign w_rs1     = {1'b0, r_lfsr[15:12]};
  assign w_rs2     = {1'b0, r_lfsr[19:16]};
  assign w_rfunct  = r_funct(w_idx_r);
  assign w_ifunct3 = i_funct3(w_idx_i);
  // Shift immediates (indices 6..8) carry a fixed funct7 over a 5-bit shamt.
  assign w_itop    = (w_idx_i >= 4'd6) ?
                     {((w_idx_i == 4'd8) ? 7'b0100000 : 7'b0000000), r_lfsr[24:20]} :
                     r_lfsr[31:20];

  // Combinational decode of the LFSR into one constrained instruction word.
  always_comb begin
    w_inst = {25'h0, OP_NOP};
    w_cls  = CLS_NOP;
    case (r_lfsr[2:0])
      3'd0, 3'd1, 3'd2: begin
        if (CLASS_EN[0]) begin
          w_cls  = CLS_R;
          w_inst = {w_rfunct[9:3], w_rs2, w_rs1, w_rfunct[2:0], w_rd, OP_R};
        end
      end
      3'd3, 3'd4: begin
        if (CLASS_EN[1]) begin
          w_cls  = CLS_I;
          w_inst = {w_itop, w_rs1, w_ifunct3, w_rd, OP_I};
        end
      end
      3'd5: begin
        if (CLASS_EN[2]) begin
          w_cls  = CLS_LW;
          w_inst = {2'b00, r_lfsr[29:20], 5'd0, 3'b010, w_rd, OP_LW};
        end
      end
      3'd6: begin
        if (CLASS_EN[3]) begin
          w_cls  = CLS_SW;
          w_inst = {2'b00, r_lfsr[28:24], w_rs2, 5'd0, 3'b010, r_lfsr[12:8], OP_SW};
        end
      end
      default: begin
        if (CLASS_EN[4]) begin
          w_cls  = CLS_NOP;
          w_inst = {r_lfsr[31:7], OP_NOP};
        end
      end
    endcase
  end

  assign out_valid   = (r_state == S_RUN);
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign count       = r_count;
  assign instruction = w_inst;
  assign inst_class  = w_cls;

endmodule

// File: tb/tb_inst_generator.sv
// Bench for inst_generator: directed run-control steps on a bounded instance,
// then a long randomized-ready run on three unbounded instances checked against
// an arithmetic reference decoder and an independent instruction-legality check.
module tb_inst_generator;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic rdy;

  logic        vld [4];
  logic [31:0] ins [4];
  logic [2:0]  cls [4];
  logic        bsy [4];
  logic        dn  [4];
  logic [15:0] cnt0, cnt1, cnt2;
  logic [9:0]  cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned R_F7 [14] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0, 1, 1, 1, 1};
  int unsigned R_F3 [14] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7, 0, 1, 2, 3};
  int unsigned I_F3 [9]  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};

  always #5 clk = ~clk;

  inst_generator #(.SEED(32'h1), .NUM_INSTS(4), .CNT_W(16), .CLASS_EN(5'b11111)) u0 (
    .clk(clk), .rst(rst), .start(start), .out_ready(rdy), .out_valid(vld[0]),
    .instruction(ins[0]), .inst_class(cls[0]), .busy(bsy[0]), .done(dn[0]), .count(cnt0));
  inst_generator #(.SEED(32'h0), .NUM_INSTS(0), .CNT_W(16), .CLASS_EN(5'b11111)) u1 (
    .clk(clk), .rst(rst), .start(start), .out_ready(rdy), .out_valid(vld[1]),
    .instruction(ins[1]), .inst_class(cls[1]), .busy(bsy[1]), .done(dn[1]), .count(cnt1));
  inst_generator #(.SEED(32'hC0FF_EE11), .NUM_INSTS(0), .CNT_W(16), .CLASS_EN(5'b00001)) u2 (
    .clk(clk), .rst(rst), .start(start), .out_ready(rdy), .out_valid(vld[2]),
    .instruction(ins[2]), .inst_class(cls[2]), .busy(bsy[2]), .done(dn[2]), .count(cnt2));
  inst_generator #(.SEED(32'h1234_5678), .NUM_INSTS(0), .CNT_W(10), .CLASS_EN(5'b11111)) u3 (
    .clk(clk), .rst(rst), .start(start), .out_ready(rdy), .out_valid(vld[3]),
    .instruction(ins[3]), .inst_class(cls[3]), .busy(bsy[3]), .done(dn[3]), .count(cnt3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] l);
    return (l >> 1) ^ ((l % 2 == 1) ? 32'h8020_0003 : 32'h0);
  endfunction

  // Reference decode written from the class/field rules with plain arithmetic.
  function automatic logic [31:0] model_inst(input logic [31:0] r, input logic [4:0] en,
                                             output logic [2:0] c);
    logic [31:0] sel, idx, rd, rs1, rs2, k, w;
    sel = r % 8;
    idx = (r >> 4) % 16;
    rd  = (r >> 8) % 16;
    rs1 = (r >> 12) % 16;
    rs2 = (r >> 16) % 16;
    if (sel <= 2)      c = 3'd0;
    else if (sel <= 4) c = 3'd1;
    else if (sel == 5) c = 3'd2;
    else if (sel == 6) c = 3'd3;
    else               c = 3'd4;
    if (en[c] == 1'b0) begin
      c = 3'd4;
      return 32'h0000_007F;
    end
    case (c)
      3'd0: begin
        k = idx % 14;
        w = (R_F7[k] << 25) | (rs2 << 20) | (rs1 << 15) | (R_F3[k] << 12) | (rd << 7) | 32'h33;
      end
      3'd1: begin
        k = idx % 9;
        if (k >= 6)
          w = (((k == 8) ? 32'd32 : 32'd0) << 25) | (((r >> 20) % 32) << 20);
        else
          w = ((r >> 20) % 4096) << 20;
        w = w | (rs1 << 15) | (I_F3[k] << 12) | (rd << 7) | 32'h13;
      end
      3'd2: w = (((r >> 20) % 1024) << 20) | (32'd2 << 12) | (rd << 7) | 32'h03;
      3'd3: w = (((r >> 24) % 32) << 25) | (rs2 << 20) | (32'd2 << 12) |
                (((r >> 8) % 32) << 7) | 32'h23;
      default: w = (r & 32'hFFFF_FF80) | 32'h7F;
    endcase
    return w;
  endfunction

  // Independent legality check of the instruction constraints on a raw word.
  function automatic bit legal(input logic [31:0] x);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = x[6:0];
    f7 = x[31:25];
    f3 = x[14:12];
    case (op)
      7'h33: return !x[11] && !x[19] && !x[24] &&
                    ((f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)) ||
                     (f7 == 7'd1 && f3 <= 3'd3));
      7'h13: return !x[11] && !x[19] &&
                    ((f3 == 3'd1) ? (f7 == 7'd0) :
                     (f3 == 3'd5) ? (f7 == 7'd0 || f7 == 7'd32) : 1'b1);
      7'h03: return !x[11] && (x[19:15] == 5'd0) && (f3 == 3'd2) && (x[31:30] == 2'b00);
      7'h23: return (x[19:15] == 5'd0) && !x[24] && (f3 == 3'd2) && (x[31:30] == 2'b00);
      7'h7F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk_u0(input string tag, input logic [31:0] l);
    logic [2:0] c;
    logic [31:0] w;
    w = model_inst(l, 5'b11111, c);
    chk({tag, "_instr"}, ins[0], w);
    chk({tag, "_class"}, {29'd0, cls[0]}, {29'd0, c});
    chk({tag, "_valid"}, {31'd0, vld[0]}, 32'd1);
  endtask

  initial begin
    logic [31:0] m;
    logic [31:0] ml [4];
    logic [4:0]  en [4];
    int unsigned hs;
    int unsigned cyc;
    logic [2:0]  c;
    logic [31:0] w;

    en[1] = 5'b11111; en[2] = 5'b00001; en[3] = 5'b11111;
    rst = 1'b1; start = 1'b0; rdy = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, vld[0]}, 32'd0);
    chk("rst_busy",  {31'd0, bsy[0]}, 32'd0);
    chk("rst_done",  {31'd0, dn[0]},  32'd0);
    chk("rst_count", {16'd0, cnt0},   32'd0);
    rst = 1'b0;
    tick();
    chk("idle_valid", {31'd0, vld[0]}, 32'd0);

    // Bounded run of four, ready held high
    rdy = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    m = 32'h1;
    chk("t1_busy", {31'd0, bsy[0]}, 32'd1);
    chk("t1_instr0_const", ins[0], 32'h0000_0033);
    for (int k = 0; k < 4; k++) begin
      chk_u0("t1", m);
      chk("t1_count", {16'd0, cnt0}, k);
      chk("t1_done_low", {31'd0, dn[0]}, 32'd0);
      if (k == 1) chk("t1_instr1_const", ins[0], 32'h8020_0013);
      tick();
      m = nxt(m);
    end
    chk("t1_done",       {31'd0, dn[0]},  32'd1);
    chk("t1_done_valid", {31'd0, vld[0]}, 32'd0);
    chk("t1_done_count", {16'd0, cnt0},   32'd4);
    tick();
    chk("t1_idle_done",  {31'd0, dn[0]},  32'd0);
    chk("t1_idle_busy",  {31'd0, bsy[0]}, 32'd0);
    chk("t1_idle_count", {16'd0, cnt0},   32'd4);

    // Back-pressure: five stalled cycles mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    m = 32'h1;
    chk_u0("t2_first", m);
    tick();
    m = nxt(m);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_u0("t2_stall", m);
      chk("t2_stall_count", {16'd0, cnt0}, 32'd1);
      tick();
    end
    rdy = 1'b1;
    for (int k = 1; k < 4; k++) begin
      chk_u0("t2_resume", m);
      chk("t2_count", {16'd0, cnt0}, k);
      tick();
      m = nxt(m);
    end
    // start raised during DONE must not launch a new run
    start = 1'b1;
    chk("t2_done", {31'd0, dn[0]}, 32'd1);
    tick();
    start = 1'b0;
    chk("t6_done_start_valid", {31'd0, vld[0]}, 32'd0);
    chk("t6_done_start_count", {16'd0, cnt0},   32'd4);
    tick();
    chk("t6_idle_valid", {31'd0, vld[0]}, 32'd0);

    // Reset in the middle of a run, then a reproducible restart
    start = 1'b1;
    tick();
    start = 1'b0;
    m = 32'h1;
    for (int k = 0; k < 2; k++) begin
      chk_u0("t4_pre", m);
      tick();
      m = nxt(m);
    end
    chk("t4_pre_count", {16'd0, cnt0}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_valid", {31'd0, vld[0]}, 32'd0);
    chk("t4_rst_count", {16'd0, cnt0},   32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_restart_instr", ins[0], 32'h0000_0033);
    repeat (4) tick();
    chk("t4_done", {31'd0, dn[0]}, 32'd1);
    tick();

    // Long randomized run on the unbounded instances
    rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    ml[1] = 32'h1; ml[2] = 32'hC0FF_EE11; ml[3] = 32'h1234_5678;
    chk("t3_seed0_instr", ins[1], 32'h0000_0033);
    hs = 0;
    cyc = 0;
    while (hs < 10000 && cyc < 40000) begin
      for (int d = 1; d < 4; d++) begin
        w = model_inst(ml[d], en[d], c);
        chk("rnd_instr", ins[d], w);
        chk("rnd_class", {29'd0, cls[d]}, {29'd0, c});
        chk("rnd_valid", {31'd0, vld[d]}, 32'd1);
        chk("rnd_done",  {31'd0, dn[d]},  32'd0);
        chk("rnd_legal", {31'd0, legal(ins[d])}, 32'd1);
      end
      chk("t3_lfsr_nonzero", {31'd0, (u1.r_lfsr != 32'h0)}, 32'd1);
      chk("t3_count", {16'd0, cnt1}, (hs > 65535) ? 32'd65535 : hs);
      chk("t5_count", {16'd0, cnt2}, (hs > 65535) ? 32'd65535 : hs);
      chk("t6_count_sat", {22'd0, cnt3}, (hs > 1023) ? 32'd1023 : hs);
      chk("t5_opcode", {31'd0, (ins[2][6:0] == 7'h33 || ins[2][6:0] == 7'h7F)}, 32'd1);
      rdy   = ($urandom_range(3) != 0);
      start = ($urandom_range(15) == 0);
      tick();
      cyc++;
      if (rdy) begin
        hs++;
        for (int d = 1; d < 4; d++) ml[d] = nxt(ml[d]);
      end
    end
    start = 1'b0;
    chk("rnd_budget", {31'd0, (hs >= 10000)}, 32'd1);
    chk("t6_count_final", {22'd0, cnt3}, 32'h3FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
